// File: rtl/mantissa_mul_sequencer_pkg.sv
// Shared definitions for the mantissa multiply sequencer.
//   sae_sel_t : select codes driven to the external ShiftAndExtend unit
//   mul_seq_t : controller states, one state per clock cycle
package mantissa_mul_sequencer_pkg;

   localparam int unsigned MANT_W = 24;
   localparam int unsigned SAE_W  = 32;
   localparam int unsigned ACC_W  = 40;

   // SHIFT_IDLE is the SAE default code; the unit drives zero outputs for it.
   typedef enum logic [1:0] {
      SHIFT_IDLE             = 2'b00,
      SHIFT_0_BIT_AND_EXTEND = 2'b01,
      SHIFT_TRUNC_AND_EXTEND = 2'b10
   } sae_sel_t;

   typedef enum logic [2:0] {
      MUL_SEQ_IDLE   = 3'd0,
      MUL_SEQ_EXTEND = 3'd1,
      MUL_SEQ_MUL_LO = 3'd2,
      MUL_SEQ_TRUNC  = 3'd3,
      MUL_SEQ_MUL_HI = 3'd4,
      MUL_SEQ_DONE   = 3'd5
   } mul_seq_t;

endpackage

// File: rtl/mantissa_mul_24x16.sv
// Combinational 24x16 unsigned multiplier producing a 40-bit product.
// One instance is shared by both multiply phases of the sequencer.
//   a : 24-bit multiplicand
//   b : 16-bit multiplier
//   p : 40-bit unsigned product
module mantissa_mul_24x16 (
   input  logic [23:0] a,
   input  logic [15:0] b,
   output logic [39:0] p
);

   assign p = {16'b0, a} * {24'b0, b};

endmodule

// File: rtl/mantissa_mul_sequencer.sv
// Multi-cycle controller forming (A*B)>>16 for 24-bit mantissas with one
// shared 24x16 multiplier, using the external ShiftAndExtend (SAE) unit for
// zero-extension of A and for truncation of the low partial product with
// sticky collection.
//   clk, reset        : clock, synchronous active-high reset
//   start_in          : multiply request, sampled only in IDLE
//   mantA_in/mantB_in : 24-bit mantissas (hidden bit included)
//   saeSelect_out     : select code to the SAE unit
//   saeOperand_out    : operand to the SAE unit
//   saeOperand_in     : combinational result from the SAE unit
//   saeSticky_in      : sticky bit from the SAE unit
//   busy_out          : high in every state except IDLE
//   done_out          : one-cycle pulse in the DONE state
//   product_out       : (A*B)>>16, held until the next result is written
//   stickyBit_out     : OR of the 16 discarded product bits
module mantissa_mul_sequencer
   import mantissa_mul_sequencer_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        start_in,
   input  logic [23:0] mantA_in,
   input  logic [23:0] mantB_in,
   output logic [1:0]  saeSelect_out,
   output logic [31:0] saeOperand_out,
   input  logic [31:0] saeOperand_in,
   input  logic        saeSticky_in,
   output logic        busy_out,
   output logic        done_out,
   output logic [31:0] product_out,
   output logic        stickyBit_out
);

   mul_seq_t    state, state_next;
   logic [23:0] reg_a, reg_b, op_a;
   logic [39:0] acc;
   logic        sticky;
   logic [15:0] mul_b;
   logic [39:0] mul_p;
   logic        sae_unused;

   // The top byte of the SAE result is never consumed.
   assign sae_unused = ^saeOperand_in[31:24];

   // MUL_HI uses the upper 8 bits of B; every other state feeds the low 16.
   assign mul_b = (state == MUL_SEQ_MUL_HI) ? {8'b0, reg_b[23:16]} : reg_b[15:0];

   mantissa_mul_24x16 u_mul (
      .a (op_a),
      .b (mul_b),
      .p (mul_p)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= MUL_SEQ_IDLE;
         reg_a         <= '0;
         reg_b         <= '0;
         op_a          <= '0;
         acc           <= '0;
         sticky        <= 1'b0;
         product_out   <= '0;
         stickyBit_out <= 1'b0;
      end else begin
         state <= state_next;
         case (state)
            MUL_SEQ_IDLE: begin
               if (start_in) begin
                  reg_a  <= mantA_in;
                  reg_b  <= mantB_in;
                  sticky <= 1'b0;
               end
            end
            MUL_SEQ_EXTEND: op_a <= saeOperand_in[23:0];
            MUL_SEQ_MUL_LO: acc  <= mul_p;
            MUL_SEQ_TRUNC: begin
               // SAE returns acc[31:16] in its low half; acc[39:32] is kept
               // locally so the shifted partial product stays exact.
               acc    <= {16'b0, acc[39:32], saeOperand_in[15:0]};
               sticky <= saeSticky_in;
            end
            MUL_SEQ_MUL_HI: acc <= acc + mul_p;
            MUL_SEQ_DONE: begin
               product_out   <= acc[31:0];
               stickyBit_out <= sticky;
               assert (acc[39:32] == 8'h00);
               if (reg_a[23] && reg_b[23]) begin
                  assert (acc[31:30] != 2'b00);
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      state_next     = state;
      saeSelect_out  = SHIFT_IDLE;
      saeOperand_out = '0;
      busy_out       = 1'b1;
      done_out       = 1'b0;
      case (state)
         MUL_SEQ_IDLE: begin
            busy_out = 1'b0;
            if (start_in) state_next = MUL_SEQ_EXTEND;
         end
         MUL_SEQ_EXTEND: begin
            saeSelect_out  = SHIFT_0_BIT_AND_EXTEND;
            saeOperand_out = {8'b0, reg_a};
            state_next     = MUL_SEQ_MUL_LO;
         end
         MUL_SEQ_MUL_LO: state_next = MUL_SEQ_TRUNC;
         MUL_SEQ_TRUNC: begin
            saeSelect_out  = SHIFT_TRUNC_AND_EXTEND;
            saeOperand_out = acc[31:0];
            state_next     = MUL_SEQ_MUL_HI;
         end
         MUL_SEQ_MUL_HI: state_next = MUL_SEQ_DONE;
         MUL_SEQ_DONE: begin
            done_out   = 1'b1;
            state_next = MUL_SEQ_IDLE;
         end
         default: state_next = MUL_SEQ_IDLE;
      endcase
   end

endmodule

// File: tb/tb_mantissa_mul_sequencer.sv
// Directed bench for mantissa_mul_sequencer with a behavioural ShiftAndExtend
// unit on the sae* ports.
module tb_mantissa_mul_sequencer;
   import mantissa_mul_sequencer_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        start_in;
   logic [23:0] mantA_in, mantB_in;
   logic [1:0]  saeSelect_out;
   logic [31:0] saeOperand_out;
   logic [31:0] saeOperand_in;
   logic        saeSticky_in;
   logic        busy_out, done_out;
   logic [31:0] product_out;
   logic        stickyBit_out;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   mantissa_mul_sequencer dut (
      .clk            (clk),
      .reset          (reset),
      .start_in       (start_in),
      .mantA_in       (mantA_in),
      .mantB_in       (mantB_in),
      .saeSelect_out  (saeSelect_out),
      .saeOperand_out (saeOperand_out),
      .saeOperand_in  (saeOperand_in),
      .saeSticky_in   (saeSticky_in),
      .busy_out       (busy_out),
      .done_out       (done_out),
      .product_out    (product_out),
      .stickyBit_out  (stickyBit_out)
   );

   // ShiftAndExtend model: 0-bit shift with zero extension of a 24-bit value,
   // or truncation of the low 16 bits with sticky collection.
   always_comb begin
      saeOperand_in = '0;
      saeSticky_in  = 1'b0;
      case (saeSelect_out)
         2'(SHIFT_0_BIT_AND_EXTEND): saeOperand_in = {8'b0, saeOperand_out[23:0]};
         2'(SHIFT_TRUNC_AND_EXTEND): begin
            saeOperand_in = {16'b0, saeOperand_out[31:16]};
            saeSticky_in  = |saeOperand_out[15:0];
         end
         default: ;
      endcase
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_ctl(input string tag, input logic eb, input logic ed,
                          input logic [1:0] es, input logic [31:0] eo);
      chk({tag, ".busy"}, 32'(busy_out), 32'(eb));
      chk({tag, ".done"}, 32'(done_out), 32'(ed));
      chk({tag, ".sel"},  32'(saeSelect_out), 32'(es));
      chk({tag, ".opnd"}, saeOperand_out, eo);
   endtask

   // Called at a negedge with start_in already high in IDLE. Walks the six
   // cycles of one operation; after EXTEND the inputs are replaced with
   // (keep_start, na, nb) to show they are not re-latched.
   task automatic run_op(input string tag, input logic [23:0] a, input logic [23:0] b,
                         input logic [31:0] exp_p, input logic exp_s,
                         input logic keep_start, input logic [23:0] na, input logic [23:0] nb);
      logic [47:0] lo;
      lo = 48'(a) * 48'(b[15:0]);
      @(negedge clk);
      chk_ctl({tag, ".extend"}, 1'b1, 1'b0, 2'(SHIFT_0_BIT_AND_EXTEND), {8'b0, a});
      start_in = keep_start;
      mantA_in = na;
      mantB_in = nb;
      @(negedge clk);
      chk_ctl({tag, ".mul_lo"}, 1'b1, 1'b0, 2'(SHIFT_IDLE), 32'h0);
      @(negedge clk);
      chk_ctl({tag, ".trunc"}, 1'b1, 1'b0, 2'(SHIFT_TRUNC_AND_EXTEND), lo[31:0]);
      @(negedge clk);
      chk_ctl({tag, ".mul_hi"}, 1'b1, 1'b0, 2'(SHIFT_IDLE), 32'h0);
      @(negedge clk);
      chk_ctl({tag, ".done"}, 1'b1, 1'b1, 2'(SHIFT_IDLE), 32'h0);
      @(negedge clk);
      chk_ctl({tag, ".idle"}, 1'b0, 1'b0, 2'(SHIFT_IDLE), 32'h0);
      chk({tag, ".product"}, product_out, exp_p);
      chk({tag, ".sticky"}, 32'(stickyBit_out), 32'(exp_s));
   endtask

   task automatic go(input logic [23:0] a, input logic [23:0] b);
      start_in = 1'b1;
      mantA_in = a;
      mantB_in = b;
   endtask

   initial begin
      reset    = 1'b1;
      start_in = 1'b0;
      mantA_in = '0;
      mantB_in = '0;
      repeat (2) @(negedge clk);
      chk_ctl("reset", 1'b0, 1'b0, 2'(SHIFT_IDLE), 32'h0);
      chk("reset.product", product_out, 32'h0);
      chk("reset.sticky", 32'(stickyBit_out), 32'h0);
      reset = 1'b0;

      // Idle with no start stays idle.
      @(negedge clk);
      chk_ctl("idle_hold", 1'b0, 1'b0, 2'(SHIFT_IDLE), 32'h0);

      go(24'h800000, 24'h800000);
      run_op("min_norm", 24'h800000, 24'h800000, 32'h40000000, 1'b0, 1'b0, '0, '0);
      go(24'hFFFFFF, 24'hFFFFFF);
      run_op("max", 24'hFFFFFF, 24'hFFFFFF, 32'hFFFFFE00, 1'b1, 1'b0, '0, '0);
      go(24'hC00000, 24'hC00000);
      run_op("c0", 24'hC00000, 24'hC00000, 32'h90000000, 1'b0, 1'b0, '0, '0);
      go(24'h800001, 24'h800000);
      run_op("a_lsb", 24'h800001, 24'h800000, 32'h40000080, 1'b0, 1'b0, '0, '0);
      go(24'h800001, 24'h800001);
      run_op("both_lsb", 24'h800001, 24'h800001, 32'h40000100, 1'b1, 1'b0, '0, '0);
      go(24'h000000, 24'h123456);
      run_op("zero", 24'h000000, 24'h123456, 32'h00000000, 1'b0, 1'b0, '0, '0);

      // Start held high through a whole op with new operands: ignored while
      // busy and in DONE, accepted in the following IDLE cycle.
      go(24'h800000, 24'h800000);
      run_op("bk2bk_1", 24'h800000, 24'h800000, 32'h40000000, 1'b0, 1'b1, 24'hFFFFFF, 24'hFFFFFF);
      run_op("bk2bk_2", 24'hFFFFFF, 24'hFFFFFF, 32'hFFFFFE00, 1'b1, 1'b0, '0, '0);

      // Reset during TRUNC aborts the op without a done pulse.
      go(24'hFFFFFF, 24'hFFFFFF);
      @(negedge clk);
      start_in = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk_ctl("abort.trunc", 1'b1, 1'b0, 2'(SHIFT_TRUNC_AND_EXTEND), 32'hFEFF0001);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk_ctl("abort.reset", 1'b0, 1'b0, 2'(SHIFT_IDLE), 32'h0);
      chk("abort.product", product_out, 32'h0);
      chk("abort.sticky", 32'(stickyBit_out), 32'h0);
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk_ctl("abort.quiet", 1'b0, 1'b0, 2'(SHIFT_IDLE), 32'h0);
      end

      go(24'hC00000, 24'hC00000);
      run_op("after_abort", 24'hC00000, 24'hC00000, 32'h90000000, 1'b0, 1'b0, '0, '0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
